// File: rtl/switch_in_arbiter_if.sv
// Requester-side and switch-side signals of the switch input arbiter.
// The arbiter uses the slave view. The requesters and the switch together use the master view.
interface switch_in_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         data;
    logic                      vld;

    modport master (
        output req, req_addr, req_data,
        input  gnt, addr, data, vld
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, addr, data, vld
    );
endinterface

// File: rtl/switch_in_arbiter.sv
// Round-robin arbiter with bounded bursts that shares the switch input port.
// The grant is combinational and the forwarded beat is registered.
module switch_in_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    switch_in_arbiter_if.slave         bus,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
);
    localparam int OWNER_W = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_BURST);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t              state_reg;
    logic [OWNER_W-1:0]  owner_reg;
    logic [OWNER_W-1:0]  rr_ptr_reg;
    logic [CNT_W-1:0]    beat_cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                vld_reg;
    logic                busy_reg;

    logic                new_burst;
    logic                cont_burst;
    logic                grant_any;
    logic [OWNER_W-1:0]  winner;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    function automatic logic [OWNER_W-1:0] next_idx(input logic [OWNER_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + OWNER_W'(1);
    endfunction

    // The first requesting index at or after start, with wrap-around. The index just before start is checked last.
    function automatic logic [OWNER_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                   input logic [OWNER_W-1:0] start);
        logic [OWNER_W-1:0] idx;
        logic [OWNER_W-1:0] pick;
        logic               found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return pick;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
            assign bus.gnt[gi]  = grant_any && (winner == OWNER_W'(gi));
        end
    endgenerate

    // Grant decision. The owner keeps the port until it drops req or uses up its burst.
    // A rotation re-arbitrates in the same cycle, so no dead cycle is inserted.
    always_comb begin
        new_burst  = 1'b0;
        cont_burst = 1'b0;
        winner     = '0;
        if (!rst) begin
            if (state_reg == ST_IDLE) begin
                if (|bus.req) begin
                    new_burst = 1'b1;
                    winner    = rr_pick(bus.req, rr_ptr_reg);
                end
            end else if (bus.req[owner_reg] && (beat_cnt_reg < MAX_CNT)) begin
                cont_burst = 1'b1;
                winner     = owner_reg;
            end else if (|bus.req) begin
                new_burst = 1'b1;
                winner    = rr_pick(bus.req, next_idx(owner_reg));
            end
        end
    end

    assign grant_any = new_burst | cont_burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            vld_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            vld_reg <= grant_any;
            if (grant_any) begin
                addr_reg <= addr_arr[winner];
                data_reg <= data_arr[winner];
            end
            if (new_burst) begin
                state_reg    <= ST_BURST;
                busy_reg     <= 1'b1;
                owner_reg    <= winner;
                beat_cnt_reg <= CNT_W'(1);
                rr_ptr_reg   <= next_idx(winner);
            end else if (cont_burst) begin
                beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            end else if (state_reg == ST_BURST) begin
                state_reg    <= ST_IDLE;
                busy_reg     <= 1'b0;
                beat_cnt_reg <= '0;
            end
        end
    end

    assign bus.addr = addr_reg;
    assign bus.data = data_reg;
    assign bus.vld  = vld_reg;
    assign owner    = owner_reg;
    assign busy     = busy_reg;
endmodule

// File: doc/switch_in_arbiter.md
Name: switch_in_arbiter

Overview:
Round-robin arbiter that shares the switch's single input port (addr/data/vld) among NUM_REQ requesters. Each cycle it grants at most one requester and forwards that requester's beat to the switch through a registered stage. A bounded burst keeps ownership with one requester for up to MAX_BURST consecutive beats before the grant rotates. It sits directly in front of the switch; its outputs drive the switch's addr, data and vld inputs.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ADDR_W, 8, address width, matches switch addr
DATA_W, 16, data width, matches switch data
MAX_BURST, 4, max consecutive beats granted to one owner (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester beat request, bit i = requester i
req_addr  in  NUM_REQ*ADDR_W  packed addresses, slice i = requester i
req_data  in  NUM_REQ*DATA_W  packed data, slice i = requester i
gnt  out  NUM_REQ  one-hot combinational grant; beat from requester i is taken this cycle
addr  out  ADDR_W  registered address to switch
data  out  DATA_W  registered data to switch
vld  out  1  registered valid to switch
owner  out  clog2(NUM_REQ)  index of current/last owner (registered)
busy  out  1  high while state is BURST

Behaviour:
- Reset (rst high at an edge): vld=0, addr=0, data=0, owner=0, busy=0, state=IDLE, beat_cnt=0, rr_ptr=0. gnt is forced to 0 whenever rst is high.
- Handshake: a requester holds req_addr/req_data stable while req is high. A beat transfers in the cycle where req[i] and gnt[i] are both high. The requester presents its next beat, or drops req, in the following cycle.
- Latency: a beat granted in cycle t appears on addr/data with vld=1 in cycle t+1. If no grant occurs in cycle t, vld=0 in cycle t+1 and addr/data hold their last values.
- No dead cycles: back-to-back grants (including ownership changes) produce continuous vld.
- States:
  - IDLE: if any req is high, grant the first set bit searching upward from rr_ptr with wrap-around. Set owner=winner, beat_cnt=1, go to BURST. If no req, stay in IDLE.
  - BURST, continue case: if req[owner] is high and beat_cnt<MAX_BURST, grant owner and increment beat_cnt.
  - BURST, rotate case: if req[owner] is low or beat_cnt==MAX_BURST, re-arbitrate in the same cycle. Search from owner+1 with wrap-around; owner is checked last. The winner gets a new burst with beat_cnt=1. If no req is high, grant nothing and go to IDLE.
- rr_ptr is updated to (winner+1) mod NUM_REQ whenever a new burst starts.
- MAX_BURST=1 yields pure per-beat round-robin.
- A sole active requester that hits MAX_BURST wins again immediately and starts a new burst with no gap.
- A req rising on a non-owner mid-burst does not preempt the owner.
- gnt is strictly one-hot or zero; it never grants a requester whose req is low.
- beat_cnt width is clog2(MAX_BURST+1) and never exceeds MAX_BURST.
- Reset mid-burst aborts the burst: no beat is forwarded for the reset cycle, and arbitration restarts from requester 0.

Test Plan:
1. Single requester 2, req high 3 cycles with addr 0x10/0x11/0x12, data 0xA0/0xA1/0xA2 -> gnt=4'b0100 for 3 cycles; vld=1 for the next 3 cycles carrying the matching addr/data; then vld=0 and addr holds 0x12.
2. All 4 requesters hold req continuously, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; vld never drops.
3. Requester 1 owns the burst and drops req after 2 beats while requester 3 requests -> gnt[3] in the very next cycle with beat_cnt=1; vld stays high.
4. Only requester 0 requests for 10 cycles, MAX_BURST=4 -> gnt[0] every cycle; vld continuous; new bursts start at beats 5 and 9; owner stays 0.
5. rst asserted during beat 2 of requester 2's burst -> next cycle vld=0, gnt=0, owner=0. After release with req[0] and req[3] high -> requester 0 wins.
6. req toggles with MAX_BURST=1 and requesters 0 and 2 active -> grants alternate 0,2,0,2; never two consecutive grants to the same index.
